// File: rtl/ctrl_rx.sv
// -----------------------------------------------------------------------------
// ctrl_rx -- receive-side command decoder for the UART command path.
//
// Consumes bytes from the UART RX block, decodes framed commands and drives
// the register file and ALU. Result bytes go to the transmit-side controller
// as latched data plus a single-cycle send flag.
//
// Command frames (command byte recognised only when idle):
//   0xAA addr data   RF write
//   0xBB addr        RF read, wait for RF_RdData_VLD
//   0xCC A B fun     write A->RF[0], B->RF[1], start ALU, wait for result
//   0xDD fun         start ALU on current operands, wait for result
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   RX_P_DATA, RX_D_VLD           received byte and its one-cycle strobe
//   RF_RdData, RF_RdData_VLD      register file read return
//   ALU_OUT, ALU_OUT_VLD          ALU result return
//   RF_WrEn, RF_RdEn              RF access pulses
//   RF_Address, RF_WrData         RF address / write data (held between cmds)
//   ALU_EN, ALU_FUN               ALU start pulse and function code
//   CLK_GATE_EN                   ALU clock-gate enable, high while ALU busy
//   RF_SEND_TX, RF_SEND_TX_FLAG   latched read byte and its ready pulse
//   ALU_OUT_LATCHED, ALU_SEND_FLAG latched ALU result and its ready pulse
// -----------------------------------------------------------------------------
module ctrl_rx #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int FUN_WIDTH  = 4,
   parameter int TIMEOUT    = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
   input  logic                    RX_D_VLD,
   input  logic [DATA_WIDTH-1:0]   RF_RdData,
   input  logic                    RF_RdData_VLD,
   input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
   input  logic                    ALU_OUT_VLD,
   output logic                    RF_WrEn,
   output logic                    RF_RdEn,
   output logic [ADDR_WIDTH-1:0]   RF_Address,
   output logic [DATA_WIDTH-1:0]   RF_WrData,
   output logic                    ALU_EN,
   output logic [FUN_WIDTH-1:0]    ALU_FUN,
   output logic                    CLK_GATE_EN,
   output logic [DATA_WIDTH-1:0]   RF_SEND_TX,
   output logic                    RF_SEND_TX_FLAG,
   output logic [2*DATA_WIDTH-1:0] ALU_OUT_LATCHED,
   output logic                    ALU_SEND_FLAG
);

   localparam logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'(8'hAA);
   localparam logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'(8'hBB);
   localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = DATA_WIDTH'(8'hCC);
   localparam logic [DATA_WIDTH-1:0] CMD_ALU_NP = DATA_WIDTH'(8'hDD);

   localparam int                CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [3:0] {
      IDLE,
      WR_ADDR,
      WR_DATA,
      RD_ADDR,
      RD_WAIT,
      OP_A,
      OP_B,
      ALU_FUN_S,
      ALU_WAIT
   } state_t;

   state_t                state;
   logic [CNT_W-1:0]      wait_cnt;
   logic [ADDR_WIDTH-1:0] addr_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state           <= IDLE;
         wait_cnt        <= '0;
         addr_q          <= '0;
         RF_WrEn         <= 1'b0;
         RF_RdEn         <= 1'b0;
         RF_Address      <= '0;
         RF_WrData       <= '0;
         ALU_EN          <= 1'b0;
         ALU_FUN         <= '0;
         CLK_GATE_EN     <= 1'b0;
         RF_SEND_TX      <= '0;
         RF_SEND_TX_FLAG <= 1'b0;
         ALU_OUT_LATCHED <= '0;
         ALU_SEND_FLAG   <= 1'b0;
      end else begin
         // NOTE: pulse outputs default low here with non-blocking assignments;
         // a later assignment in the case below wins, giving one-cycle pulses.
         RF_WrEn         <= 1'b0;
         RF_RdEn         <= 1'b0;
         ALU_EN          <= 1'b0;
         RF_SEND_TX_FLAG <= 1'b0;
         ALU_SEND_FLAG   <= 1'b0;

         case (state)
            IDLE: begin
               if (RX_D_VLD) begin
                  case (RX_P_DATA)
                     CMD_WR:     state <= WR_ADDR;
                     CMD_RD:     state <= RD_ADDR;
                     CMD_ALU_OP: state <= OP_A;
                     CMD_ALU_NP: state <= ALU_FUN_S;
                     default:    state <= IDLE;
                  endcase
               end
            end

            WR_ADDR: begin
               if (RX_D_VLD) begin
                  addr_q <= RX_P_DATA[ADDR_WIDTH-1:0];
                  state  <= WR_DATA;
               end
            end

            WR_DATA: begin
               if (RX_D_VLD) begin
                  RF_WrEn    <= 1'b1;
                  RF_Address <= addr_q;
                  RF_WrData  <= RX_P_DATA;
                  state      <= IDLE;
               end
            end

            RD_ADDR: begin
               if (RX_D_VLD) begin
                  RF_RdEn    <= 1'b1;
                  RF_Address <= RX_P_DATA[ADDR_WIDTH-1:0];
                  wait_cnt   <= '0;
                  state      <= RD_WAIT;
               end
            end

            // Incoming RX bytes are deliberately ignored while waiting.
            // A valid strobe takes priority over an expiring timeout.
            RD_WAIT: begin
               if (RF_RdData_VLD) begin
                  RF_SEND_TX      <= RF_RdData;
                  RF_SEND_TX_FLAG <= 1'b1;
                  state           <= IDLE;
               end else if (wait_cnt == CNT_LAST) begin
                  state <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end

            // Operands A and B always land in RF locations 0 and 1.
            OP_A: begin
               if (RX_D_VLD) begin
                  RF_WrEn    <= 1'b1;
                  RF_Address <= '0;
                  RF_WrData  <= RX_P_DATA;
                  state      <= OP_B;
               end
            end

            OP_B: begin
               if (RX_D_VLD) begin
                  RF_WrEn    <= 1'b1;
                  RF_Address <= ADDR_WIDTH'(1);
                  RF_WrData  <= RX_P_DATA;
                  state      <= ALU_FUN_S;
               end
            end

            ALU_FUN_S: begin
               if (RX_D_VLD) begin
                  ALU_FUN     <= RX_P_DATA[FUN_WIDTH-1:0];
                  ALU_EN      <= 1'b1;
                  CLK_GATE_EN <= 1'b1;
                  wait_cnt    <= '0;
                  state       <= ALU_WAIT;
               end
            end

            // Clock gate stays open until a result arrives or we give up.
            ALU_WAIT: begin
               if (ALU_OUT_VLD) begin
                  ALU_OUT_LATCHED <= ALU_OUT;
                  ALU_SEND_FLAG   <= 1'b1;
                  CLK_GATE_EN     <= 1'b0;
                  state           <= IDLE;
               end else if (wait_cnt == CNT_LAST) begin
                  CLK_GATE_EN <= 1'b0;
                  state       <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ctrl_rx.sv
// -----------------------------------------------------------------------------
// tb_ctrl_rx -- self-checking bench for ctrl_rx.
//
// A monitor turns every output pulse into a tagged event word. Each command is
// driven as a byte frame with random gaps; the expected event list and the
// expected held output values are derived from the command semantics alone.
// -----------------------------------------------------------------------------
module tb_ctrl_rx;

   localparam int DW = 8;
   localparam int AW = 4;
   localparam int FW = 4;
   localparam int TO = 32;

   localparam int K_WR      = 0;
   localparam int K_RD      = 1;
   localparam int K_ALUOP   = 2;
   localparam int K_ALUNOOP = 3;
   localparam int K_JUNK    = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [DW-1:0]   RX_P_DATA = '0;
   logic            RX_D_VLD = 1'b0;
   logic [DW-1:0]   RF_RdData = '0;
   logic            RF_RdData_VLD = 1'b0;
   logic [2*DW-1:0] ALU_OUT = '0;
   logic            ALU_OUT_VLD = 1'b0;
   logic            RF_WrEn;
   logic            RF_RdEn;
   logic [AW-1:0]   RF_Address;
   logic [DW-1:0]   RF_WrData;
   logic            ALU_EN;
   logic [FW-1:0]   ALU_FUN;
   logic            CLK_GATE_EN;
   logic [DW-1:0]   RF_SEND_TX;
   logic            RF_SEND_TX_FLAG;
   logic [2*DW-1:0] ALU_OUT_LATCHED;
   logic            ALU_SEND_FLAG;

   ctrl_rx #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .FUN_WIDTH (FW),
      .TIMEOUT   (TO)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .RX_P_DATA      (RX_P_DATA),
      .RX_D_VLD       (RX_D_VLD),
      .RF_RdData      (RF_RdData),
      .RF_RdData_VLD  (RF_RdData_VLD),
      .ALU_OUT        (ALU_OUT),
      .ALU_OUT_VLD    (ALU_OUT_VLD),
      .RF_WrEn        (RF_WrEn),
      .RF_RdEn        (RF_RdEn),
      .RF_Address     (RF_Address),
      .RF_WrData      (RF_WrData),
      .ALU_EN         (ALU_EN),
      .ALU_FUN        (ALU_FUN),
      .CLK_GATE_EN    (CLK_GATE_EN),
      .RF_SEND_TX     (RF_SEND_TX),
      .RF_SEND_TX_FLAG(RF_SEND_TX_FLAG),
      .ALU_OUT_LATCHED(ALU_OUT_LATCHED),
      .ALU_SEND_FLAG  (ALU_SEND_FLAG)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   // Event words: [31:24] kind, low bits payload.
   logic [31:0] obs_q[$];
   logic [31:0] exp_q[$];

   // Expected values of the held outputs.
   logic [AW-1:0]   m_addr  = '0;
   logic [DW-1:0]   m_wdata = '0;
   logic [FW-1:0]   m_fun   = '0;
   logic [DW-1:0]   m_send  = '0;
   logic [2*DW-1:0] m_alu   = '0;

   logic prev_rfs  = 1'b0;
   logic prev_alus = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] ev_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      return {8'd1, 12'd0, a, d};
   endfunction
   function automatic logic [31:0] ev_rd(input logic [AW-1:0] a);
      return {8'd2, 20'd0, a};
   endfunction
   function automatic logic [31:0] ev_alu(input logic [FW-1:0] f);
      return {8'd3, 20'd0, f};
   endfunction
   function automatic logic [31:0] ev_rfs(input logic [DW-1:0] d);
      return {8'd4, 16'd0, d};
   endfunction
   function automatic logic [31:0] ev_alus(input logic [2*DW-1:0] r);
      return {8'd5, 8'd0, r};
   endfunction

   // Monitor: sample outputs on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (rst) begin
         if (RF_WrEn)         obs_q.push_back(ev_wr(RF_Address, RF_WrData));
         if (RF_RdEn)         obs_q.push_back(ev_rd(RF_Address));
         if (ALU_EN)          obs_q.push_back(ev_alu(ALU_FUN));
         if (RF_SEND_TX_FLAG) obs_q.push_back(ev_rfs(RF_SEND_TX));
         if (ALU_SEND_FLAG)   obs_q.push_back(ev_alus(ALU_OUT_LATCHED));
         if (RF_SEND_TX_FLAG || ALU_SEND_FLAG)
            check("flags_exclusive", 32'(RF_SEND_TX_FLAG & ALU_SEND_FLAG), 32'd0);
         if (RF_SEND_TX_FLAG) check("rf_flag_width", 32'(prev_rfs), 32'd0);
         if (ALU_SEND_FLAG)   check("alu_flag_width", 32'(prev_alus), 32'd0);
      end
      prev_rfs  <= RF_SEND_TX_FLAG;
      prev_alus <= ALU_SEND_FLAG;
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_wren"},  32'(RF_WrEn), 32'd0);
      check({tag, "_rden"},  32'(RF_RdEn), 32'd0);
      check({tag, "_addr"},  32'(RF_Address), 32'd0);
      check({tag, "_wdata"}, 32'(RF_WrData), 32'd0);
      check({tag, "_aluen"}, 32'(ALU_EN), 32'd0);
      check({tag, "_fun"},   32'(ALU_FUN), 32'd0);
      check({tag, "_gate"},  32'(CLK_GATE_EN), 32'd0);
      check({tag, "_stx"},   32'(RF_SEND_TX), 32'd0);
      check({tag, "_stxf"},  32'(RF_SEND_TX_FLAG), 32'd0);
      check({tag, "_alul"},  32'(ALU_OUT_LATCHED), 32'd0);
      check({tag, "_aluf"},  32'(ALU_SEND_FLAG), 32'd0);
   endtask

   // Called and returns on a falling edge.
   task automatic send_byte(input logic [7:0] b, input int gap);
      repeat (gap) @(negedge clk);
      RX_P_DATA = b;
      RX_D_VLD  = 1'b1;
      @(negedge clk);
      RX_D_VLD  = 1'b0;
   endtask

   // Entered on the falling edge right after the byte that opened the wait.
   // The result strobe is driven in the j==d cycle; it is accepted only if it
   // is sampled within the first TO cycles of the wait (d <= TO-1).
   task automatic wait_resp(input bit is_alu, input int d, input logic [2*DW-1:0] res,
                            input bit inject);
      bit          hit = (d <= TO - 1);
      logic [7:0]  inj = 8'($urandom);
      for (int j = 0; j <= TO + 2; j++) begin
         if (hit && j == d + 1) begin
            if (is_alu) begin
               check("alu_flag_pulse", 32'(ALU_SEND_FLAG), 32'd1);
               check("gate_off_on_vld", 32'(CLK_GATE_EN), 32'd0);
            end else begin
               check("rf_flag_pulse", 32'(RF_SEND_TX_FLAG), 32'd1);
            end
         end
         if (is_alu && j == TO - 1) check("gate_last_wait_cycle", 32'(CLK_GATE_EN), 32'(d >= TO - 1));
         if (is_alu && j == TO)     check("gate_after_timeout", 32'(CLK_GATE_EN), 32'd0);
         RX_D_VLD      = inject && (d >= 1) && (j == 1);
         RX_P_DATA     = inj;
         RF_RdData     = DW'($urandom);
         ALU_OUT       = (2*DW)'($urandom);
         RF_RdData_VLD = 1'b0;
         ALU_OUT_VLD   = 1'b0;
         if (j == d) begin
            if (is_alu) begin
               ALU_OUT     = res;
               ALU_OUT_VLD = 1'b1;
            end else begin
               RF_RdData     = res[DW-1:0];
               RF_RdData_VLD = 1'b1;
            end
         end
         @(negedge clk);
      end
      RX_D_VLD      = 1'b0;
      RF_RdData_VLD = 1'b0;
      ALU_OUT_VLD   = 1'b0;
   endtask

   task automatic run_cmd(input int kind, input logic [7:0] p0, input logic [7:0] p1,
                          input logic [7:0] p2, input int d, input logic [2*DW-1:0] res,
                          input bit inject, input int gmax);
      bit hit = (d <= TO - 1);
      obs_q.delete();
      exp_q.delete();
      case (kind)
         K_WR: begin
            send_byte(8'hAA, $urandom_range(0, gmax));
            send_byte(p0, $urandom_range(0, gmax));
            send_byte(p1, $urandom_range(0, gmax));
            check("wr_pulse_timing", 32'(RF_WrEn), 32'd1);
            exp_q.push_back(ev_wr(p0[AW-1:0], p1));
            m_addr  = p0[AW-1:0];
            m_wdata = p1;
         end
         K_RD: begin
            send_byte(8'hBB, $urandom_range(0, gmax));
            send_byte(p0, $urandom_range(0, gmax));
            check("rd_pulse_timing", 32'(RF_RdEn), 32'd1);
            exp_q.push_back(ev_rd(p0[AW-1:0]));
            m_addr = p0[AW-1:0];
            if (hit) begin
               exp_q.push_back(ev_rfs(res[DW-1:0]));
               m_send = res[DW-1:0];
            end
            wait_resp(1'b0, d, res, inject);
         end
         K_ALUOP: begin
            send_byte(8'hCC, $urandom_range(0, gmax));
            send_byte(p0, $urandom_range(0, gmax));
            check("opa_pulse_timing", 32'(RF_WrEn), 32'd1);
            send_byte(p1, $urandom_range(0, gmax));
            send_byte(p2, $urandom_range(0, gmax));
            check("aluen_timing", 32'(ALU_EN), 32'd1);
            check("gate_on", 32'(CLK_GATE_EN), 32'd1);
            exp_q.push_back(ev_wr(AW'(0), p0));
            exp_q.push_back(ev_wr(AW'(1), p1));
            exp_q.push_back(ev_alu(p2[FW-1:0]));
            m_addr  = AW'(1);
            m_wdata = p1;
            m_fun   = p2[FW-1:0];
            if (hit) begin
               exp_q.push_back(ev_alus(res));
               m_alu = res;
            end
            wait_resp(1'b1, d, res, inject);
         end
         K_ALUNOOP: begin
            send_byte(8'hDD, $urandom_range(0, gmax));
            send_byte(p0, $urandom_range(0, gmax));
            check("aluen_timing", 32'(ALU_EN), 32'd1);
            check("gate_on", 32'(CLK_GATE_EN), 32'd1);
            exp_q.push_back(ev_alu(p0[FW-1:0]));
            m_fun = p0[FW-1:0];
            if (hit) begin
               exp_q.push_back(ev_alus(res));
               m_alu = res;
            end
            wait_resp(1'b1, d, res, inject);
         end
         default: begin
            send_byte(p0, $urandom_range(0, gmax));
         end
      endcase
      repeat (3) @(negedge clk);
      check("event_count", 32'(obs_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
         check("event", (i < obs_q.size()) ? obs_q[i] : 32'hxxxxxxxx, exp_q[i]);
      check("hold_addr",  32'(RF_Address), 32'(m_addr));
      check("hold_wdata", 32'(RF_WrData), 32'(m_wdata));
      check("hold_fun",   32'(ALU_FUN), 32'(m_fun));
      check("hold_stx",   32'(RF_SEND_TX), 32'(m_send));
      check("hold_alul",  32'(ALU_OUT_LATCHED), 32'(m_alu));
      check("idle_gate",  32'(CLK_GATE_EN), 32'd0);
   endtask

   initial begin
      int         kind;
      logic [7:0] b0;
      logic [7:0] b1;
      logic [7:0] b2;
      int         dly;

      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b1;
      @(negedge clk);

      // Directed cases.
      run_cmd(K_WR,      8'h05, 8'h3C, 8'h00, 99, 16'h0000, 1'b0, 0);
      run_cmd(K_RD,      8'h07, 8'h00, 8'h00, 3,  16'h005A, 1'b0, 0);
      run_cmd(K_ALUOP,   8'h12, 8'h34, 8'h00, 4,  16'h0046, 1'b0, 0);
      run_cmd(K_JUNK,    8'h55, 8'h00, 8'h00, 99, 16'h0000, 1'b0, 0);
      run_cmd(K_ALUNOOP, 8'h02, 8'h00, 8'h00, 99, 16'h0000, 1'b0, 0);
      run_cmd(K_WR,      8'hBB, 8'hCC, 8'h00, 99, 16'h0000, 1'b0, 0);
      // Timeout boundaries: last accepted cycle and first late cycle.
      run_cmd(K_RD,      8'h03, 8'h00, 8'h00, TO - 1, 16'h00C3, 1'b1, 1);
      run_cmd(K_RD,      8'h04, 8'h00, 8'h00, TO,     16'h00D4, 1'b1, 1);
      run_cmd(K_ALUNOOP, 8'h0F, 8'h00, 8'h00, TO - 1, 16'hBEEF, 1'b1, 1);
      run_cmd(K_ALUOP,   8'hAA, 8'hDD, 8'hCC, TO,     16'h1234, 1'b1, 1);

      // Reset in the middle of a write frame.
      obs_q.delete();
      send_byte(8'hAA, 0);
      send_byte(8'h03, 0);
      rst = 1'b0;
      #1;
      check_all_zero("midreset");
      repeat (2) @(negedge clk);
      rst = 1'b1;
      m_addr = '0; m_wdata = '0; m_fun = '0; m_send = '0; m_alu = '0;
      @(negedge clk);
      send_byte(8'h77, 0);
      repeat (2) @(negedge clk);
      check("no_write_after_reset", 32'(obs_q.size()), 32'd0);
      run_cmd(K_WR, 8'h01, 8'hFF, 8'h00, 99, 16'h0000, 1'b0, 0);

      // Randomized commands.
      for (int n = 0; n < 150; n++) begin
         kind = $urandom_range(0, 4);
         b0   = 8'($urandom);
         b1   = 8'($urandom);
         b2   = 8'($urandom);
         if (kind == K_JUNK)
            while (b0 == 8'hAA || b0 == 8'hBB || b0 == 8'hCC || b0 == 8'hDD)
               b0 = 8'($urandom);
         case ($urandom_range(0, 7))
            0:       dly = 99;
            1, 2:    dly = $urandom_range(TO - 4, TO + 2);
            default: dly = $urandom_range(0, 10);
         endcase
         run_cmd(kind, b0, b1, b2, dly, (2*DW)'($urandom), 1'($urandom), 2);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
